reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that retires them in program order.
// Accepts one dispatch, one CDB writeback and one commit per cycle; a mispredicted commit flushes it.
module reorder_buffer #(
  parameter int ROB_DEPTH    = 64,
  parameter int ROB_IDX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    dispatch_we,
  input  logic [4:0]              dispatch_rd,
  input  logic [5:0]              dispatch_pd,
  input  logic [63:0]             dispatch_order,
  output logic [ROB_IDX_BITS-1:0] rob_num,
  output logic                    rob_full,

  input  logic                    cdb_valid,
  input  logic [ROB_IDX_BITS-1:0] cdb_rob_num,
  input  logic                    cdb_mispredict,

  output logic                    commit_valid,
  output logic [4:0]              commit_rd,
  output logic [5:0]              commit_pd,
  output logic [63:0]             commit_order,
  output logic                    flush
);

  // Dispatch handshake: dispatch_we is a valid with no per-cycle ready. The dispatcher
  // samples rob_full through a register, so rob_full rises one entry early; a dispatch
  // that still arrives with the buffer completely full is dropped without side effects.

  localparam logic [ROB_IDX_BITS:0]   CNT_MAX     = (ROB_IDX_BITS+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_BITS:0]   FULL_THRESH = (ROB_IDX_BITS+1)'(ROB_DEPTH - 1);
  localparam logic [ROB_IDX_BITS:0]   CNT_ONE     = (ROB_IDX_BITS+1)'(1);
  localparam logic [ROB_IDX_BITS-1:0] PTR_ONE     = ROB_IDX_BITS'(1);

  // Per-entry status bits (reset) and payload (not reset, written on allocation only)
  logic [ROB_DEPTH-1:0]    ent_valid;
  logic [ROB_DEPTH-1:0]    ent_ready;
  logic [ROB_DEPTH-1:0]    ent_mispredict;
  logic [4:0]              ent_rd    [ROB_DEPTH];
  logic [5:0]              ent_pd    [ROB_DEPTH];
  logic [63:0]             ent_order [ROB_DEPTH];

  logic [ROB_IDX_BITS-1:0] head;
  logic [ROB_IDX_BITS-1:0] tail;
  logic [ROB_IDX_BITS:0]   count;

  logic                    head_commit;
  logic                    do_flush;
  logic                    do_alloc;
  logic                    do_wb;

  // Commit looks only at registered state, so a writeback to the head retires next cycle.
  // Reset gates it so nothing retires while the buffer is being discarded.
  always_comb begin
    head_commit = ent_valid[head] & ent_ready[head] & ~rst;
    do_flush    = head_commit & ent_mispredict[head];
    do_alloc    = dispatch_we & (count != CNT_MAX) & ~do_flush & ~rst;
    do_wb       = cdb_valid & ent_valid[cdb_rob_num] & ~do_flush & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst || do_flush) begin
      ent_valid      <= '0;
      ent_ready      <= '0;
      ent_mispredict <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
    end else begin
      if (do_wb) begin
        ent_ready[cdb_rob_num]      <= 1'b1;
        ent_mispredict[cdb_rob_num] <= cdb_mispredict;
      end
      // Allocation never collides with the writeback or commit slot: tail only equals
      // head when the buffer is empty (head invalid) or full (allocation blocked).
      if (do_alloc) begin
        ent_valid[tail]      <= 1'b1;
        ent_ready[tail]      <= 1'b0;
        ent_mispredict[tail] <= 1'b0;
        tail                 <= tail + PTR_ONE;
      end
      if (head_commit) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_ONE;
      end
      case ({do_alloc, head_commit})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) begin
      ent_rd[tail]    <= dispatch_rd;
      ent_pd[tail]    <= dispatch_pd;
      ent_order[tail] <= dispatch_order;
    end
  end

  always_comb begin
    rob_num      = tail;
    rob_full     = (count >= FULL_THRESH);
    commit_valid = head_commit;
    flush        = do_flush;
    commit_rd    = '0;
    commit_pd    = '0;
    commit_order = '0;
    if (head_commit) begin
      commit_rd    = ent_rd[head];
      commit_pd    = ent_pd[head];
      commit_order = ent_order[head];
    end
  end

endmodule
